lab2_mem_sched: RTL and testbench

Two-requester scheduler for the Lab 2 memory-primitive datapath, i.e. the single data register plus addressed memory driven by `save_data`, `write_en`, `show_reg` and `d_in`. It accepts whole write/read transactions from two clients, arbitrates between them round-robin, and converts each transaction into the datapath's strobe sequence. It sits between the clients and the datapath, so neither client drives datapath strobes directly.

---
 rtl/lab2_mem_sched.sv | 80 ++++++++
 tb/tb_lab2_mem_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_mem_sched.sv
// lab2_mem_sched: round-robin scheduler for two clients that turns whole write/read
// transactions into the save_data / write_en / show_reg strobe sequence of the Lab 2 datapath.
module lab2_mem_sched #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*DW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            grant_id,
  output logic            dp_save_data,
  output logic            dp_write_en,
  output logic            dp_show_reg,
  output logic [DW-1:0]   dp_d_in,
  input  logic [DW-1:0]   dp_d_out
);
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, SHOW, DONE} state_t;
  state_t state;
  logic rr;
  logic win;
  logic [DW-1:0] addr_q;
  assign win = &req ? rr : req[1];
  // strobes are loaded on the edge entering each state so they are stable for the whole cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ack <= '0;
      rdata <= '0;
      busy <= 1'b0;
      grant_id <= 1'b0;
      rr <= 1'b0;
      addr_q <= '0;
      dp_save_data <= 1'b0;
      dp_write_en <= 1'b0;
      dp_show_reg <= 1'b0;
      dp_d_in <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (|req) begin
          state <= we[win] ? LOAD : SHOW;
          busy <= 1'b1;
          grant_id <= win;
          rr <= ~win;
          addr_q <= addr[DW*win +: DW];
          dp_save_data <= we[win];
          dp_show_reg <= ~we[win];
          dp_d_in <= we[win] ? wdata[DW*win +: DW] : addr[DW*win +: DW];
        end
        LOAD: begin
          state <= COMMIT;
          dp_save_data <= 1'b0;
          dp_write_en <= 1'b1;
          dp_d_in <= addr_q;
        end
        COMMIT: begin
          state <= DONE;
          dp_write_en <= 1'b0;
          dp_d_in <= '0;
          ack[grant_id] <= 1'b1;
        end
        SHOW: begin
          state <= DONE;
          dp_show_reg <= 1'b0;
          dp_d_in <= '0;
          rdata <= dp_d_out;
          ack[grant_id] <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_lab2_mem_sched.sv
// tb_lab2_mem_sched: scoreboard bench with a behavioural datapath and a transaction-level memory model.
module tb_lab2_mem_sched;
  logic clk, rst;
  logic r_req [2];
  logic r_we [2];
  logic [7:0] r_addr [2];
  logic [7:0] r_wdata [2];
  logic [1:0] req, we, ack;
  logic [15:0] addr, wdata;
  logic [7:0] rdata, dp_d_in, dp_d_out;
  logic busy, grant_id, dp_save_data, dp_write_en, dp_show_reg;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign req = {r_req[1], r_req[0]};
  assign we = {r_we[1], r_we[0]};
  assign addr = {r_addr[1], r_addr[0]};
  assign wdata = {r_wdata[1], r_wdata[0]};

  lab2_mem_sched #(.DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .dp_save_data(dp_save_data), .dp_write_en(dp_write_en), .dp_show_reg(dp_show_reg),
    .dp_d_in(dp_d_in), .dp_d_out(dp_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath: one register plus addressed memory, untouched by the scheduler reset
  bit [7:0] dp_reg;
  bit [7:0] dp_mem [256];
  always @(posedge clk) begin
    if (dp_save_data) dp_reg <= dp_d_in;
    if (dp_write_en) dp_mem[dp_d_in] <= dp_reg;
  end
  assign dp_d_out = dp_show_reg ? dp_mem[dp_d_in] : dp_reg;

  typedef struct packed {
    logic busy, sv, wen, show;
    logic [7:0] din;
    logic [1:0] ack;
  } exp_t;
  typedef struct {
    int c;
    bit rd;
    logic [7:0] data;
  } sb_t;

  exp_t exp_tab [int];
  sb_t sbq [$];
  bit [7:0] ref_mem [256];
  bit rr_pref;
  int free_at = 0;
  bit pend_valid;
  int pend_cyc;
  bit [7:0] pend_a, pend_d;

  // predictor: decides each grant from the live request levels and schedules the expected cycles
  always @(negedge clk) begin
    int w;
    sb_t s;
    if (!rst) begin
      exp_tab.delete();
      sbq.delete();
      pend_valid = 0;
      rr_pref = 0;
      free_at = 0;
    end else begin
      if (pend_valid && cyc > pend_cyc) begin
        ref_mem[pend_a] = pend_d;
        pend_valid = 0;
      end
      if (cyc >= free_at && (r_req[0] || r_req[1])) begin
        w = (r_req[0] && r_req[1]) ? int'(rr_pref) : (r_req[1] ? 1 : 0);
        rr_pref = (w == 0);
        s.c = w;
        if (r_we[w]) begin
          exp_tab[cyc+1] = '{busy: 1'b1, sv: 1'b1, wen: 1'b0, show: 1'b0, din: r_wdata[w], ack: 2'b00};
          exp_tab[cyc+2] = '{busy: 1'b1, sv: 1'b0, wen: 1'b1, show: 1'b0, din: r_addr[w], ack: 2'b00};
          exp_tab[cyc+3] = '{busy: 1'b1, sv: 1'b0, wen: 1'b0, show: 1'b0, din: 8'h00, ack: 2'(1 << w)};
          pend_valid = 1;
          pend_cyc = cyc + 2;
          pend_a = r_addr[w];
          pend_d = r_wdata[w];
          free_at = cyc + 4;
          s.rd = 0;
          s.data = 8'h00;
        end else begin
          exp_tab[cyc+1] = '{busy: 1'b1, sv: 1'b0, wen: 1'b0, show: 1'b1, din: r_addr[w], ack: 2'b00};
          exp_tab[cyc+2] = '{busy: 1'b1, sv: 1'b0, wen: 1'b0, show: 1'b0, din: 8'h00, ack: 2'(1 << w)};
          free_at = cyc + 3;
          s.rd = 1;
          s.data = ref_mem[r_addr[w]];
        end
        sbq.push_back(s);
      end
    end
  end

  // monitor: compares every cycle against the schedule and pops the scoreboard on each ack
  logic [7:0] exp_rdata = 8'h00;
  always @(negedge clk) begin
    exp_t e, act;
    sb_t s;
    act = {busy, dp_save_data, dp_write_en, dp_show_reg, dp_d_in, ack};
    if (!rst) begin
      exp_rdata = 8'h00;
      checks++;
      if (act !== '0 || rdata !== 8'h00 || grant_id !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got outs=%b rdata=%h grant_id=%b required all zero", act, rdata, grant_id);
      end
    end else begin
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
      if (exp_tab.exists(cyc)) exp_tab.delete(cyc);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d got busy,sv,we,show,din,ack=%b required %b", cyc, act, e);
      end
      if (ack !== 2'b00) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack cyc=%0d got ack=%b required no ack", cyc, ack);
        end else begin
          s = sbq.pop_front();
          if (grant_id !== 1'(s.c)) begin
            failures++;
            $display("FAIL grant_id cyc=%0d got %0d required %0d", cyc, grant_id, s.c);
          end
          if (s.rd) exp_rdata = s.data;
        end
      end
      checks++;
      if (rdata !== exp_rdata) begin
        failures++;
        $display("FAIL rdata cyc=%0d got %h required %h", cyc, rdata, exp_rdata);
      end
    end
  end

  task automatic wait_ack(input int c);
    int n = 0;
    while (ack[c] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (ack[c] !== 1'b1) begin
      failures++;
      $display("FAIL ack_wait client=%0d got ack=%b required ack[%0d]=1", c, ack, c);
    end
  endtask

  task automatic client_txn(input int c, input bit w, input logic [7:0] a, input logic [7:0] d, input bit hold);
    r_we[c] = w;
    r_addr[c] = a;
    r_wdata[c] = d;
    r_req[c] = 1'b1;
    wait_ack(c);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      r_req[c] = 1'b0;
      wait_ack(c);
    end
    @(posedge clk);
    #1;
    r_req[c] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_client(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      client_txn(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0;
      r_we[i] = 1'b0;
      r_addr[i] = 8'h00;
      r_wdata[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    client_txn(0, 1'b1, 8'h01, 8'h15, 1'b0);
    client_txn(0, 1'b0, 8'h01, 8'h00, 1'b0);
    checks++;
    if (rdata !== 8'h15) begin
      failures++;
      $display("FAIL read_back_0x01 got %h required 15", rdata);
    end
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    fork
      client_txn(0, 1'b1, 8'h02, 8'hA3, 1'b0);
      client_txn(1, 1'b1, 8'h03, 8'h87, 1'b0);
    join
    client_txn(0, 1'b0, 8'h02, 8'h00, 1'b0);
    checks++;
    if (rdata !== 8'hA3) begin
      failures++;
      $display("FAIL read_back_0x02 got %h required a3", rdata);
    end
    client_txn(1, 1'b0, 8'h03, 8'h00, 1'b0);
    checks++;
    if (rdata !== 8'h87) begin
      failures++;
      $display("FAIL read_back_0x03 got %h required 87", rdata);
    end
    fork
      repeat (3) client_txn(0, 1'b0, 8'($urandom_range(0, 7)), 8'h00, 1'b0);
      repeat (3) client_txn(1, 1'b0, 8'($urandom_range(0, 7)), 8'h00, 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    r_we[0] = 1'b1;
    r_addr[0] = 8'h01;
    r_wdata[0] = 8'h55;
    r_req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    r_req[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    client_txn(0, 1'b0, 8'h01, 8'h00, 1'b0);
    checks++;
    if (rdata !== 8'h15) begin
      failures++;
      $display("FAIL abandoned_write got %h required 15", rdata);
    end
    client_txn(1, 1'b1, 8'h04, 8'h3C, 1'b1);
    client_txn(1, 1'b0, 8'h04, 8'h00, 1'b1);
    fork
      rand_client(0, 30);
      rand_client(1, 30);
    join
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
